// File: rtl/led_blink_scheduler_pkg.sv
// Shared types and elaboration helpers for the LED blink scheduler.
// Imported by the config interface, the channel sub-module and the top.
package led_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cfg_state_t;

  // Prescaler divide ratio; the top rejects non-integer or < 2 results at elaboration.
  function automatic int div_calc(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Channel-index width, never narrower than one bit.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_if.sv
// Valid/ready configuration port of the LED blink scheduler.
// The master (buttons, UART decoder) drives a request; the scheduler answers with ready.
interface led_blink_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = led_sched_pkg::CNT_W_DEF
);

  localparam int CH_W = led_sched_pkg::ch_w(NCH);

  logic             CFG_VALID;
  logic             CFG_READY;
  logic [CH_W-1:0]  CFG_CH;
  logic             CFG_EN;
  logic [CNT_W-1:0] CFG_PERIOD;
  logic [CNT_W-1:0] CFG_ON;

  modport master (
    output CFG_VALID, CFG_CH, CFG_EN, CFG_PERIOD, CFG_ON,
    input  CFG_READY
  );

  modport slave (
    input  CFG_VALID, CFG_CH, CFG_EN, CFG_PERIOD, CFG_ON,
    output CFG_READY
  );

endinterface

// File: rtl/led_blink_scheduler_channel.sv
// One blink channel: holds its settings, a tick-driven phase counter and
// a registered LED output that lags the phase by one clock.
module led_channel
  import led_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             tick,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on,
  output logic             led
);

  logic             en_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] on_q;
  logic [CNT_W-1:0] phase;
  logic             led_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      en_q     <= 1'b0;
      period_q <= '0;
      on_q     <= '0;
      phase    <= '0;
    end else if (tick) begin
      if (load) begin
        en_q     <= en;
        period_q <= period;
        on_q     <= on;
        phase    <= '0;
      end else if ((period_q == '0) || (phase == period_q - 1'b1)) begin
        // A zero period parks the phase at 0 instead of running through the full range.
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // The phase counts even while disabled, so enabling later keeps the pattern aligned.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      led_q <= 1'b0;
    end else begin
      led_q <= en_q && (period_q != '0) && (phase < on_q);
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_scheduler.sv
// Multi-channel LED blink controller: one shared tick prescaler, a config FSM
// that applies requests on the next tick, and NCH independent blink channels.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  led_blink_scheduler_if.slave  cfg,
  output logic                  TICK,
  output logic [NCH-1:0]        BOARD_LED
);

  localparam int DIV   = div_calc(CLK_HZ, TICK_HZ);
  localparam int PRE_W = $clog2(DIV);
  localparam int CH_W  = ch_w(NCH);

  if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
    $error("led_blink_scheduler: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if ((NCH < 1) || (NCH > 8)) begin : g_bad_nch
    $error("led_blink_scheduler: NCH must be in 1..8");
  end

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] on;
  } pend_t;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_q;
  cfg_state_t       state;
  pend_t            pend;
  logic             ready_q;
  logic             load_tick;
  logic [NCH-1:0]   load_vec;

  // TICK is registered, so it is high in the cycle after the count reaches DIV-1.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (pre_cnt == PRE_W'(DIV - 1)) begin
      pre_cnt <= '0;
      tick_q  <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick_q  <= 1'b0;
    end
  end

  // A tick in the accept cycle is ignored because the FSM is still in IDLE then.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      pend    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg.CFG_VALID && ready_q) begin
            pend.ch     <= cfg.CFG_CH;
            pend.en     <= cfg.CFG_EN;
            pend.period <= cfg.CFG_PERIOD;
            pend.on     <= cfg.CFG_ON;
            ready_q     <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tick_q) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_tick     = (state == ST_WAIT) && tick_q;
  assign cfg.CFG_READY = ready_q;
  assign TICK          = tick_q;

  // An out-of-range index matches no channel, so the request is simply dropped.
  always_comb begin
    // NOTE: the default assignment first keeps this purely combinational; any
    // bit left unassigned on some path would otherwise infer a latch.
    load_vec = '0;
    if (load_tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend.ch == CH_W'(i)) begin
          load_vec[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .tick   (tick_q),
      .load   (load_vec[i]),
      .en     (pend.en),
      .period (pend.period),
      .on     (pend.on),
      .led    (BOARD_LED[i])
    );
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler at DIV=12: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range channel index.
module tb_led_blink_scheduler;
  import led_sched_pkg::*;

  localparam int CLK_HZ  = 12;
  localparam int TICK_HZ = 1;
  localparam int NCH     = 4;
  localparam int NCH_B   = 3;
  localparam int CNT_W   = 16;
  localparam int CH_A    = ch_w(NCH);
  localparam int CH_B    = ch_w(NCH_B);

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic             tick_a, tick_b;
  logic [NCH-1:0]   led_a;
  logic [NCH_B-1:0] led_b;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  led_blink_scheduler_if #(.NCH(NCH),   .CNT_W(CNT_W)) cfg_a ();
  led_blink_scheduler_if #(.NCH(NCH_B), .CNT_W(CNT_W)) cfg_b ();

  led_blink_scheduler #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(NCH), .CNT_W(CNT_W)
  ) dut_a (
    .CLK(CLK), .RSTN(RSTN), .cfg(cfg_a), .TICK(tick_a), .BOARD_LED(led_a)
  );

  led_blink_scheduler #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(NCH_B), .CNT_W(CNT_W)
  ) dut_b (
    .CLK(CLK), .RSTN(RSTN), .cfg(cfg_b), .TICK(tick_b), .BOARD_LED(led_b)
  );

  function automatic logic [3:0] leds(input bit sel);
    return sel ? {1'b0, led_b} : led_a;
  endfunction

  function automatic logic tick_of(input bit sel);
    return sel ? tick_b : tick_a;
  endfunction

  function automatic logic ready_of(input bit sel);
    return sel ? cfg_b.CFG_READY : cfg_a.CFG_READY;
  endfunction

  task automatic set_cfg(input bit sel, input bit valid, input int ch, input bit en,
                         input int period, input int on);
    if (sel) begin
      cfg_b.CFG_VALID  = valid;
      cfg_b.CFG_CH     = CH_B'(ch);
      cfg_b.CFG_EN     = en;
      cfg_b.CFG_PERIOD = CNT_W'(period);
      cfg_b.CFG_ON     = CNT_W'(on);
    end else begin
      cfg_a.CFG_VALID  = valid;
      cfg_a.CFG_CH     = CH_A'(ch);
      cfg_a.CFG_EN     = en;
      cfg_a.CFG_PERIOD = CNT_W'(period);
      cfg_a.CFG_ON     = CNT_W'(on);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (5) @(negedge CLK);
    RSTN = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_tick(input bit sel, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!tick_of(sel) && cycles < 40);
    if (!tick_of(sel)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL tick_timeout: no TICK within %0d cycles", cycles);
    end
  endtask

  task automatic sample_now(input bit sel, input string tag);
    logic [3:0] exp;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, led=%b", tag, leds(sel));
    end else begin
      exp = exp_q.pop_front();
      if (leds(sel) !== exp) begin
        tests_failed++;
        $display("FAIL %s: led=%b expected %b", tag, leds(sel), exp);
      end
    end
  endtask

  // LED reflects a tick's phase two clocks after the tick cycle.
  task automatic check_ticks(input bit sel, input int n, input string tag);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_tick(sel, c);
      @(negedge CLK);
      @(negedge CLK);
      sample_now(sel, tag);
    end
  endtask

  // Called at a negedge; returns at the first negedge with READY high again.
  task automatic do_cfg(input bit sel, input int ch, input bit en, input int period,
                        input int on, output int wait_cycles);
    int n = 0;
    while (!ready_of(sel) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!ready_of(sel)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cfg_ready_timeout: ready=%b expected 1", ready_of(sel));
    end
    set_cfg(sel, 1'b1, ch, en, period, on);
    @(negedge CLK);
    set_cfg(sel, 1'b0, 0, 1'b0, 0, 0);
    wait_cycles = 1;
    while (!ready_of(sel) && wait_cycles < 40) begin
      @(negedge CLK);
      wait_cycles++;
    end
    if (!ready_of(sel)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cfg_done_timeout: ready=%b expected 1", ready_of(sel));
    end
  endtask

  task automatic test_reset();
    int c;
    set_cfg(1'b0, 1'b0, 0, 1'b0, 0, 0);
    set_cfg(1'b1, 1'b0, 0, 1'b0, 0, 0);
    RSTN = 1'b0;
    repeat (5) @(negedge CLK);
    tests_run++;
    if (led_a !== 4'b0000 || led_b !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_led: led_a=%b led_b=%b expected 0", led_a, led_b);
    end
    tests_run++;
    if (cfg_a.CFG_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: ready=%b expected 1", cfg_a.CFG_READY);
    end
    tests_run++;
    if (tick_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tick: tick=%b expected 0", tick_a);
    end
    RSTN = 1'b1;
    wait_tick(1'b0, c);
    tests_run++;
    if (c != 12) begin
      tests_failed++;
      $display("FAIL first_tick: %0d cycles expected 12", c);
    end
    wait_tick(1'b0, c);
    tests_run++;
    if (c != 12) begin
      tests_failed++;
      $display("FAIL tick_period: %0d cycles expected 12", c);
    end
    @(negedge CLK);
    tests_run++;
    if (tick_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL tick_width: tick=%b expected 0", tick_a);
    end
  endtask

  task automatic test_basic_blink();
    int w;
    apply_reset();
    do_cfg(1'b0, 0, 1'b1, 4, 2, w);
    tests_run++;
    if (w != 13) begin
      tests_failed++;
      $display("FAIL basic_ready_low: ready back after %0d cycles expected 13", w);
    end
    tests_run++;
    if (led_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_led_lag: led=%b expected 0000", led_a);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 4) < 2 ? 4'b0001 : 4'b0000);
    @(negedge CLK);
    sample_now(1'b0, "basic_first");
    check_ticks(1'b0, 7, "basic_blink");
  endtask

  task automatic test_accept_on_tick();
    int c;
    apply_reset();
    wait_tick(1'b0, c);
    set_cfg(1'b0, 1'b1, 1, 1'b1, 2, 1);
    @(negedge CLK);
    set_cfg(1'b0, 1'b0, 0, 1'b0, 0, 0);
    tests_run++;
    if (cfg_a.CFG_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL coinc_ready: ready=%b expected 0", cfg_a.CFG_READY);
    end
    wait_tick(1'b0, c);
    tests_run++;
    if (c != 11 || cfg_a.CFG_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL coinc_load_tick: gap=%0d ready=%b expected gap 11 ready 0", c, cfg_a.CFG_READY);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    @(negedge CLK);
    tests_run++;
    if (cfg_a.CFG_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL coinc_ready_back: ready=%b expected 1", cfg_a.CFG_READY);
    end
    @(negedge CLK);
    sample_now(1'b0, "coinc_first");
    check_ticks(1'b0, 3, "coinc_blink");
  endtask

  task automatic test_edge_values();
    int w;
    apply_reset();
    do_cfg(1'b0, 1, 1'b1, 0, 3, w);
    do_cfg(1'b0, 2, 1'b1, 3, 5, w);
    do_cfg(1'b0, 3, 1'b0, 4, 2, w);
    repeat (6) exp_q.push_back(4'b0100);
    check_ticks(1'b0, 6, "edge_values");
  endtask

  task automatic test_reprogram();
    int w;
    apply_reset();
    do_cfg(1'b0, 0, 1'b1, 4, 2, w);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    @(negedge CLK);
    sample_now(1'b0, "reprog_before");
    check_ticks(1'b0, 3, "reprog_before");
    do_cfg(1'b0, 0, 1'b1, 2, 1, w);
    tests_run++;
    if (w != 11) begin
      tests_failed++;
      $display("FAIL reprog_wait: ready back after %0d cycles expected 11", w);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    @(negedge CLK);
    sample_now(1'b0, "reprog_first");
    check_ticks(1'b0, 4, "reprog_after");
  endtask

  task automatic test_reset_in_wait();
    int c;
    int w;
    apply_reset();
    wait_tick(1'b0, c);
    @(negedge CLK);
    set_cfg(1'b0, 1'b1, 0, 1'b1, 4, 2);
    @(negedge CLK);
    set_cfg(1'b0, 1'b0, 0, 1'b0, 0, 0);
    tests_run++;
    if (cfg_a.CFG_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_ready: ready=%b expected 0", cfg_a.CFG_READY);
    end
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    tests_run++;
    if (cfg_a.CFG_READY !== 1'b1 || led_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wait_reset: ready=%b led=%b expected 1 0000", cfg_a.CFG_READY, led_a);
    end
    repeat (3) exp_q.push_back(4'b0000);
    check_ticks(1'b0, 3, "wait_reset_dropped");

    apply_reset();
    do_cfg(1'b1, 3, 1'b1, 2, 1, w);
    tests_run++;
    if (w != 13) begin
      tests_failed++;
      $display("FAIL range_ready: ready back after %0d cycles expected 13", w);
    end
    repeat (3) exp_q.push_back(4'b0000);
    check_ticks(1'b1, 3, "range_no_change");
    do_cfg(1'b1, 2, 1'b1, 2, 1, w);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0100);
    @(negedge CLK);
    sample_now(1'b1, "range_valid_ch");
    check_ticks(1'b1, 2, "range_valid_ch");
  endtask

  initial begin
    test_reset();
    test_basic_blink();
    test_accept_on_tick();
    test_edge_values();
    test_reprogram();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
